// File: rtl/tilemap_ram_scheduler_if.sv
// CPU-side request/acknowledge bus for the tilemap RAM scheduler.
//   cpu_req   : access request, level, held until cpu_ack
//   cpu_we    : 1 = write, 0 = read; stable while cpu_req is high
//   cpu_addr  : 13-bit RAM byte address; stable while cpu_req is high
//   cpu_wdata : write data; stable while cpu_req is high
//   cpu_rdata : read data, valid with cpu_ack and held until the next read completes
//   cpu_ack   : one-cycle completion pulse
// master = CPU bus glue, slave = scheduler.
interface tilemap_ram_scheduler_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack
  );
endinterface

// File: rtl/tilemap_ram_scheduler.sv
// Time-slot scheduler for the shared 8Kx8 tilemap RAM.
// An 8-cycle frame on CLK_6M (optionally realigned by the falling edge of nHSYNC) gives
// slots 0/1 to layer A {code, attr}, slots 2/3 to layer B, and everything else to one CPU
// requester through a req/ack handshake.
// Ports:
//   CLK_6M, rst        : pixel clock, synchronous active-high reset
//   nHSYNC             : horizontal sync, active low
//   cpu                : CPU request/ack bus (slave side)
//   la_idx, lb_idx     : layer tile indices, latched entering slot 0 / slot 2
//   la_data, la_valid  : layer A entry {attr, code} and its one-cycle update pulse
//   lb_data, lb_valid  : layer B entry and pulse
//   slot               : current slot counter
//   RA, RD_in, RD_out, RD_oe, nROE, nRWE : RAM pins
module tilemap_ram_scheduler #(
  parameter logic [1:0] LAYER_EN    = 2'b11,
  parameter bit         HSYNC_ALIGN = 1'b1
) (
  input  logic                          CLK_6M,
  input  logic                          rst,
  input  logic                          nHSYNC,
  tilemap_ram_scheduler_if.slave        cpu,
  input  logic [10:0]                   la_idx,
  input  logic [10:0]                   lb_idx,
  output logic [15:0]                   la_data,
  output logic                          la_valid,
  output logic [15:0]                   lb_data,
  output logic                          lb_valid,
  output logic [2:0]                    slot,
  output logic [12:0]                   RA,
  input  logic [7:0]                    RD_in,
  output logic [7:0]                    RD_out,
  output logic                          RD_oe,
  output logic                          nROE,
  output logic                          nRWE
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StPend   = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StAck    = 2'd3;

  logic [2:0]  cnt_q, cnt_d;
  logic        hs_q, fall_q;
  logic        realign;
  logic [10:0] la_idx_q, lb_idx_q;
  logic [7:0]  la_lo_q, lb_lo_q;
  logic [15:0] la_data_q, lb_data_q;
  logic        la_valid_q, lb_valid_q;
  logic [1:0]  state_q, state_d;
  logic        we_q;
  logic [12:0] addr_q;
  logic [7:0]  wdata_q, rdata_q;

  // Slots 4-7 always belong to the CPU; a disabled layer donates its pair as well.
  function automatic logic is_cpu_slot(input logic [2:0] s);
    is_cpu_slot = s[2] | (s[1] ? ~LAYER_EN[1] : ~LAYER_EN[0]);
  endfunction

  assign realign = HSYNC_ALIGN && fall_q;
  assign cnt_d   = realign ? 3'd0 : cnt_q + 3'd1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cpu.cpu_req) state_d = is_cpu_slot(cnt_d) ? StAccess : StPend;
      StPend:   if (is_cpu_slot(cnt_d)) state_d = StAccess;
      StAccess: state_d = StAck;
      StAck:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      cnt_q      <= 3'd0;
      hs_q       <= 1'b1;
      fall_q     <= 1'b0;
      la_idx_q   <= '0;
      lb_idx_q   <= '0;
      la_lo_q    <= '0;
      lb_lo_q    <= '0;
      la_data_q  <= '0;
      lb_data_q  <= '0;
      la_valid_q <= 1'b0;
      lb_valid_q <= 1'b0;
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      hs_q       <= nHSYNC;
      fall_q     <= hs_q & ~nHSYNC;
      state_q    <= state_d;
      la_valid_q <= 1'b0;
      lb_valid_q <= 1'b0;

      if (cnt_d == 3'd0) la_idx_q <= la_idx;
      if (cnt_d == 3'd2) lb_idx_q <= lb_idx;

      // A realign on the edge closing the second byte drops the whole pair.
      if (LAYER_EN[0]) begin
        if (cnt_q == 3'd0) la_lo_q <= RD_in;
        if (cnt_q == 3'd1 && !realign) begin
          la_data_q  <= {RD_in, la_lo_q};
          la_valid_q <= 1'b1;
        end
      end
      if (LAYER_EN[1]) begin
        if (cnt_q == 3'd2) lb_lo_q <= RD_in;
        if (cnt_q == 3'd3 && !realign) begin
          lb_data_q  <= {RD_in, lb_lo_q};
          lb_valid_q <= 1'b1;
        end
      end

      if (state_q == StIdle && cpu.cpu_req) begin
        we_q    <= cpu.cpu_we;
        addr_q  <= cpu.cpu_addr;
        wdata_q <= cpu.cpu_wdata;
      end
      if (state_q == StAccess && !we_q) rdata_q <= RD_in;
    end
  end

  // RAM pins come only from registered state; rst forces them idle.
  always_comb begin
    RA    = '0;
    nROE  = 1'b1;
    nRWE  = 1'b1;
    RD_oe = 1'b0;
    if (!rst) begin
      if (!is_cpu_slot(cnt_q)) begin
        RA   = {cnt_q[1], (cnt_q[1] ? lb_idx_q : la_idx_q), cnt_q[0]};
        nROE = 1'b0;
      end else if (state_q == StAccess) begin
        RA = addr_q;
        if (we_q) begin
          nRWE  = 1'b0;
          RD_oe = 1'b1;
        end else begin
          nROE = 1'b0;
        end
      end
    end
  end

  assign RD_out        = wdata_q;
  assign cpu.cpu_rdata = rdata_q;
  assign cpu.cpu_ack   = (state_q == StAck);
  assign la_data       = la_data_q;
  assign la_valid      = la_valid_q;
  assign lb_data       = lb_data_q;
  assign lb_valid      = lb_valid_q;
  assign slot          = cnt_q;

endmodule

// File: tb/tb_tilemap_ram_scheduler.sv
module tb_tilemap_ram_scheduler;

  logic CLK_6M = 1'b0;
  always #5 CLK_6M = ~CLK_6M;

  logic        rst;
  logic        nHSYNC;
  logic [10:0] la_idx, lb_idx, idx2_zero;

  // Main DUT (both layers enabled)
  logic [15:0] la_data, lb_data;
  logic        la_valid, lb_valid;
  logic [2:0]  slot;
  logic [12:0] RA;
  logic [7:0]  RD_in, RD_out;
  logic        RD_oe, nROE, nRWE;

  // Second DUT with layer B disabled
  logic [15:0] la_data2, lb_data2;
  logic        la_valid2, lb_valid2;
  logic [2:0]  slot2;
  logic [12:0] RA2;
  logic [7:0]  RD_in2, RD_out2;
  logic        RD_oe2, nROE2, nRWE2;

  tilemap_ram_scheduler_if cpu_bus ();
  tilemap_ram_scheduler_if cpu_bus2 ();

  tilemap_ram_scheduler #(.LAYER_EN(2'b11), .HSYNC_ALIGN(1'b1)) u_dut (
    .CLK_6M(CLK_6M), .rst(rst), .nHSYNC(nHSYNC), .cpu(cpu_bus),
    .la_idx(la_idx), .lb_idx(lb_idx),
    .la_data(la_data), .la_valid(la_valid), .lb_data(lb_data), .lb_valid(lb_valid),
    .slot(slot), .RA(RA), .RD_in(RD_in), .RD_out(RD_out), .RD_oe(RD_oe),
    .nROE(nROE), .nRWE(nRWE)
  );

  tilemap_ram_scheduler #(.LAYER_EN(2'b01), .HSYNC_ALIGN(1'b1)) u_dut2 (
    .CLK_6M(CLK_6M), .rst(rst), .nHSYNC(nHSYNC), .cpu(cpu_bus2),
    .la_idx(idx2_zero), .lb_idx(idx2_zero),
    .la_data(la_data2), .la_valid(la_valid2), .lb_data(lb_data2), .lb_valid(lb_valid2),
    .slot(slot2), .RA(RA2), .RD_in(RD_in2), .RD_out(RD_out2), .RD_oe(RD_oe2),
    .nROE(nROE2), .nRWE(nRWE2)
  );

  // RAM models
  logic [7:0] ram  [0:8191];
  logic [7:0] ram2 [0:8191];
  assign RD_in  = ram[RA];
  assign RD_in2 = ram2[RA2];
  always @(negedge CLK_6M) begin
    if (!rst && !nRWE)  ram[RA]   = RD_out;
    if (!rst && !nRWE2) ram2[RA2] = RD_out2;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred that is required not to", name);
  endtask

  typedef struct packed {
    logic        we;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [2:0]  acc_slot;
    logic [2:0]  ack_slot;
  } txn_t;

  txn_t exp_q[$];
  txn_t exp2_q[$];

  logic        rst_at_edge;
  always @(posedge CLK_6M) rst_at_edge <= rst;

  // Monitor for the main DUT: layer strobes, CPU accesses, acks and layer pulses.
  logic [10:0] la_lat, lb_lat;
  logic [12:0] exp_ra;
  txn_t        tm;
  int          la_seen = 0;
  always @(negedge CLK_6M) begin
    if (slot == 3'd0) la_lat = rst_at_edge ? 11'd0 : la_idx;
    if (slot == 3'd2) lb_lat = lb_idx;
    if (!rst) begin
      if (slot < 3'd4) begin
        exp_ra = {slot[1], (slot[1] ? lb_lat : la_lat), slot[0]};
        check("layer_strobe", 32'({RA, nROE, nRWE, RD_oe}), 32'({exp_ra, 3'b010}));
      end else if (!nROE || !nRWE) begin
        if (exp_q.size() == 0) fail_now("cpu_unexpected_strobe");
        else begin
          tm = exp_q[0];
          check("cpu_access", 32'({slot, RA, nROE, nRWE, RD_oe, (tm.we ? RD_out : 8'h00)}),
                32'({tm.acc_slot, tm.addr, tm.we, ~tm.we, tm.we, (tm.we ? tm.wdata : 8'h00)}));
        end
      end
      if (cpu_bus.cpu_ack) begin
        if (exp_q.size() == 0) fail_now("cpu_unexpected_ack");
        else begin
          tm = exp_q.pop_front();
          check("cpu_ack", 32'({slot, cpu_bus.cpu_rdata}), 32'({tm.ack_slot, tm.rdata}));
        end
      end
      if (la_valid) begin
        la_seen++;
        check("la_pulse", 32'({slot, la_data}),
              32'({3'd2, ram[{1'b0, la_lat, 1'b1}], ram[{1'b0, la_lat, 1'b0}]}));
      end
      if (lb_valid)
        check("lb_pulse", 32'({slot, lb_data}),
              32'({3'd4, ram[{1'b1, lb_lat, 1'b1}], ram[{1'b1, lb_lat, 1'b0}]}));
    end
  end

  // Monitor for the layer-B-disabled DUT.
  txn_t t2;
  int   lb2_cnt = 0;
  always @(negedge CLK_6M) begin
    if (!rst) begin
      if (lb_valid2) lb2_cnt++;
      if (slot2 >= 3'd2 && (!nROE2 || !nRWE2)) begin
        if (exp2_q.size() == 0) fail_now("cpu2_unexpected_strobe");
        else begin
          t2 = exp2_q[0];
          check("cpu2_access", 32'({slot2, RA2, nROE2, nRWE2, RD_oe2}),
                32'({t2.acc_slot, t2.addr, t2.we, ~t2.we, t2.we}));
        end
      end
      if (cpu_bus2.cpu_ack) begin
        if (exp2_q.size() == 0) fail_now("cpu2_unexpected_ack");
        else begin
          t2 = exp2_q.pop_front();
          check("cpu2_ack", 32'({slot2, cpu_bus2.cpu_rdata}), 32'({t2.ack_slot, t2.rdata}));
        end
      end
    end
  end

  task automatic wait_slot(input bit sel, input logic [2:0] s);
    int n = 0;
    do begin
      @(posedge CLK_6M);
      #1;
      n++;
    end while (((sel ? slot2 : slot) != s) && n < 20);
    if ((sel ? slot2 : slot) != s) fail_now("wait_slot_timeout");
  endtask

  task automatic start_txn(input bit sel, input logic [2:0] s, input logic we,
                           input logic [12:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rdata, input logic [2:0] acc,
                           input logic [2:0] ack);
    txn_t t;
    wait_slot(sel, s);
    t = '{we: we, addr: addr, wdata: wdata, rdata: rdata, acc_slot: acc, ack_slot: ack};
    if (sel) begin
      exp2_q.push_back(t);
      cpu_bus2.cpu_we = we; cpu_bus2.cpu_addr = addr; cpu_bus2.cpu_wdata = wdata;
      cpu_bus2.cpu_req = 1'b1;
    end else begin
      exp_q.push_back(t);
      cpu_bus.cpu_we = we; cpu_bus.cpu_addr = addr; cpu_bus.cpu_wdata = wdata;
      cpu_bus.cpu_req = 1'b1;
    end
  endtask

  task automatic wait_ack(input bit sel);
    int n = 0;
    do begin
      @(negedge CLK_6M);
      n++;
    end while (!(sel ? cpu_bus2.cpu_ack : cpu_bus.cpu_ack) && n < 20);
    if (!(sel ? cpu_bus2.cpu_ack : cpu_bus.cpu_ack)) fail_now("ack_timeout");
    if (sel) cpu_bus2.cpu_req = 1'b0;
    else     cpu_bus.cpu_req  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; nHSYNC = 1'b1;
    la_idx = 11'h123; lb_idx = 11'h055; idx2_zero = 11'h000;
    cpu_bus.cpu_req = 1'b0;  cpu_bus.cpu_we = 1'b0;
    cpu_bus.cpu_addr = '0;   cpu_bus.cpu_wdata = '0;
    cpu_bus2.cpu_req = 1'b0; cpu_bus2.cpu_we = 1'b0;
    cpu_bus2.cpu_addr = '0;  cpu_bus2.cpu_wdata = '0;
    for (int i = 0; i < 8192; i++) begin
      ram[i] = 8'h00;
      ram2[i] = 8'h00;
    end
    ram[13'h0000] = 8'hA1; ram[13'h0001] = 8'hB2;
    ram[13'h0246] = 8'h5A; ram[13'h0247] = 8'hC3;
    ram[13'h10AA] = 8'h11; ram[13'h10AB] = 8'h22;
    ram[13'h0010] = 8'h9E; ram[13'h0FFF] = 8'h5C;
    ram2[13'h0005] = 8'h3C;

    // Reset state
    repeat (3) @(posedge CLK_6M);
    @(negedge CLK_6M);
    check("reset_pins", 32'({slot, RA, nROE, nRWE, RD_oe}), 32'({3'd0, 13'h0, 3'b110}));
    check("reset_pulses", 32'({cpu_bus.cpu_ack, la_valid, lb_valid, cpu_bus.cpu_rdata}), 32'd0);
    check("reset_data", {la_data, lb_data}, 32'd0);
    @(posedge CLK_6M);
    #1 rst = 1'b0;

    // Layer fetch, second frame (index latch starts at 0 after reset)
    wait_slot(1'b0, 3'd0);
    check("la_ra_slot0", 32'({RA, nROE}), 32'({13'h0246, 1'b0}));
    wait_slot(1'b0, 3'd1);
    check("la_ra_slot1", 32'({RA, nROE}), 32'({13'h0247, 1'b0}));
    wait_slot(1'b0, 3'd2);
    check("la_fetch", 32'({la_valid, la_data}), 32'h1C35A);
    wait_slot(1'b0, 3'd4);
    check("lb_fetch", 32'({lb_valid, lb_data}), 32'h12211);

    // Layer B disabled: request during slot 1 uses slot 2, ack in slot 3
    start_txn(1'b1, 3'd1, 1'b0, 13'h0005, 8'h00, 8'h3C, 3'd2, 3'd3);
    wait_ack(1'b1);

    // CPU write during slot 3 -> access 4, ack 5
    start_txn(1'b0, 3'd3, 1'b1, 13'h1ABC, 8'h77, 8'h00, 3'd4, 3'd5);
    wait_ack(1'b0);
    check("ram_write", 32'(ram[13'h1ABC]), 32'h77);
    // Worst-case read: sampled entering slot 0
    start_txn(1'b0, 3'd7, 1'b0, 13'h0010, 8'h00, 8'h9E, 3'd4, 3'd5);
    wait_ack(1'b0);
    // Minimum latency read
    start_txn(1'b0, 3'd4, 1'b0, 13'h1ABC, 8'h00, 8'h77, 3'd5, 3'd6);
    wait_ack(1'b0);
    // Ack lands on the frame wrap
    start_txn(1'b0, 3'd6, 1'b0, 13'h0FFF, 8'h00, 8'h5C, 3'd7, 3'd0);
    wait_ack(1'b0);
    // Write keeps the last read data on cpu_rdata
    start_txn(1'b0, 3'd5, 1'b1, 13'h0020, 8'hE1, 8'h5C, 3'd6, 3'd7);
    wait_ack(1'b0);
    start_txn(1'b0, 3'd1, 1'b0, 13'h0020, 8'h00, 8'hE1, 3'd4, 3'd5);
    wait_ack(1'b0);

    // Realign: nHSYNC falls during slot 5 -> 6, then 0
    wait_slot(1'b0, 3'd5);
    nHSYNC = 1'b0;
    @(posedge CLK_6M); #1;
    check("realign_step1", 32'(slot), 32'd6);
    @(posedge CLK_6M); #1;
    check("realign_step2", 32'(slot), 32'd0);
    nHSYNC = 1'b1;

    // Realign while a request is pending
    start_txn(1'b0, 3'd0, 1'b0, 13'h0010, 8'h00, 8'h9E, 3'd4, 3'd5);
    @(posedge CLK_6M); #1;
    nHSYNC = 1'b0;
    @(posedge CLK_6M); #1;
    check("pend_realign_a", 32'(slot), 32'd2);
    @(posedge CLK_6M); #1;
    check("pend_realign_b", 32'(slot), 32'd0);
    nHSYNC = 1'b1;
    wait_ack(1'b0);

    // Reset mid-PEND: request dropped, no ack
    wait_slot(1'b0, 3'd0);
    cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 13'h0010; cpu_bus.cpu_req = 1'b1;
    @(posedge CLK_6M); #1;
    rst = 1'b1;
    cpu_bus.cpu_req = 1'b0;
    #1;
    check("rst_pins_inactive", 32'({RA, nROE, nRWE, RD_oe, cpu_bus.cpu_ack}),
          32'({13'h0, 4'b1100}));
    @(posedge CLK_6M); #1;
    rst = 1'b0;
    check("rst_cnt_restart", 32'(slot), 32'd0);
    @(posedge CLK_6M); #1;
    check("rst_cnt_next", 32'(slot), 32'd1);
    repeat (16) @(posedge CLK_6M);
    #1;

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("sb2_drained", 32'(exp2_q.size()), 32'd0);
    check("lb2_never_valid", 32'(lb2_cnt), 32'd0);
    check("la_pulses_seen", 32'(la_seen >= 5), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
